// File: rtl/fft_pkg.sv
// Shared types and size constants for the FFT control sequencer.
package fft_pkg;

  // Default transform size and the widths derived from it.
  localparam int FFT_LOG2_N = 5;
  localparam int FFT_N      = 1 << FFT_LOG2_N;
  localparam int FFT_HALF_N = FFT_N / 2;
  localparam int CNT_W      = FFT_LOG2_N;
  localparam int ITER_W     = FFT_LOG2_N - 1;
  localparam int STAGE_W    = $clog2(FFT_LOG2_N);

  // Sequencer phase; the encoding is driven straight onto input_mode.
  typedef enum logic [1:0] {
    MODE_IDLE    = 2'b00,
    MODE_LOAD    = 2'b01,
    MODE_COMPUTE = 2'b10,
    MODE_UNLOAD  = 2'b11
  } mode_e;

endpackage

// File: rtl/fft_stage_counter.sv
// Nested butterfly / gap / stage counters that pace the COMPUTE phase.
module fft_stage_counter #(
  parameter int LOG2_N    = 5,
  parameter int STAGE_GAP = 2
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        clr,
  input  logic                        start,
  input  logic                        en,
  output logic [LOG2_N-2:0]           iteration_count,
  output logic [$clog2(LOG2_N)-1:0]   stage_count,
  output logic                        bfly_en,
  output logic                        compute_done
);

  localparam int ITER_W  = LOG2_N - 1;
  localparam int STAGE_W = $clog2(LOG2_N);
  localparam int HALF_N  = 1 << (LOG2_N - 1);
  localparam int GAP_W   = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  logic [GAP_W-1:0]   gap_count;
  logic               in_gap;
  logic [ITER_W-1:0]  iter_next;
  logic [STAGE_W-1:0] stage_next;
  logic [GAP_W-1:0]   gap_next;
  logic               in_gap_next;
  logic               bfly_next;
  logic               iter_last;
  logic               gap_last;
  logic               stage_last;
  logic               stage_end;

  assign iter_last  = (iteration_count == ITER_W'(HALF_N - 1));
  assign gap_last   = in_gap && (gap_count == GAP_W'(STAGE_GAP - 1));
  assign stage_last = (stage_count == STAGE_W'(LOG2_N - 1));
  // With no gap the stage ends on its last butterfly, otherwise on the last gap cycle.
  assign stage_end    = en && ((STAGE_GAP == 0) ? (!in_gap && iter_last) : gap_last);
  assign compute_done = stage_end && stage_last;

  // Next-value logic: clear beats start, start beats advance.
  always_comb begin
    iter_next   = iteration_count;
    stage_next  = stage_count;
    gap_next    = gap_count;
    in_gap_next = in_gap;
    bfly_next   = bfly_en;
    if (clr) begin
      iter_next   = ITER_W'(0);
      stage_next  = STAGE_W'(0);
      gap_next    = GAP_W'(0);
      in_gap_next = 1'b0;
      bfly_next   = 1'b0;
    end else if (start) begin
      iter_next   = ITER_W'(0);
      stage_next  = STAGE_W'(0);
      gap_next    = GAP_W'(0);
      in_gap_next = 1'b0;
      bfly_next   = 1'b1;
    end else if (en) begin
      if (compute_done) begin
        iter_next   = ITER_W'(0);
        stage_next  = STAGE_W'(0);
        gap_next    = GAP_W'(0);
        in_gap_next = 1'b0;
        bfly_next   = 1'b0;
      end else if (stage_end) begin
        iter_next   = ITER_W'(0);
        stage_next  = stage_count + STAGE_W'(1);
        gap_next    = GAP_W'(0);
        in_gap_next = 1'b0;
        bfly_next   = 1'b1;
      end else if (in_gap) begin
        gap_next  = gap_count + GAP_W'(1);
        bfly_next = 1'b0;
      end else if (iter_last) begin
        // Last butterfly issued: hold the index and let the pipeline drain.
        gap_next    = GAP_W'(0);
        in_gap_next = 1'b1;
        bfly_next   = 1'b0;
      end else begin
        iter_next = iteration_count + ITER_W'(1);
        bfly_next = 1'b1;
      end
    end else begin
      bfly_next = bfly_en;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      iteration_count <= ITER_W'(0);
      stage_count     <= STAGE_W'(0);
      gap_count       <= GAP_W'(0);
      in_gap          <= 1'b0;
      bfly_en         <= 1'b0;
    end else begin
      iteration_count <= iter_next;
      stage_count     <= stage_next;
      gap_count       <= gap_next;
      in_gap          <= in_gap_next;
      bfly_en         <= bfly_next;
    end
  end

endmodule

// File: rtl/fft_sequencer.sv
// Frame sequencer: LOAD samples, run all radix-2 stages, UNLOAD results.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2_N    = FFT_LOG2_N,
  parameter int STAGE_GAP = 2
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [1:0]                  input_mode,
  output logic [LOG2_N-1:0]           samples_in_count,
  output logic [LOG2_N-1:0]           samples_out_count,
  output logic [LOG2_N-2:0]           iteration_count,
  output logic [$clog2(LOG2_N)-1:0]   stage_count,
  output logic                        bfly_en,
  output logic                        busy,
  output logic                        done
);

  localparam int N    = 1 << LOG2_N;
  localparam int CW   = LOG2_N;

  mode_e          state;
  mode_e          state_next;
  logic [CW-1:0]  in_next;
  logic [CW-1:0]  out_next;
  logic           done_next;
  logic           cnt_start;
  logic           cnt_en;
  logic           compute_done;

  assign input_mode   = state;
  assign sample_ready = (state == MODE_LOAD);
  assign out_valid    = (state == MODE_UNLOAD);
  assign busy         = (state != MODE_IDLE);
  assign cnt_en       = (state == MODE_COMPUTE) && !abort;

  fft_stage_counter #(
    .LOG2_N    (LOG2_N),
    .STAGE_GAP (STAGE_GAP)
  ) u_stage_counter (
    .clk             (clk),
    .nrst            (nrst),
    .clr             (abort),
    .start           (cnt_start),
    .en              (cnt_en),
    .iteration_count (iteration_count),
    .stage_count     (stage_count),
    .bfly_en         (bfly_en),
    .compute_done    (compute_done)
  );

  // Next-state and counter decisions; abort overrides every other input.
  always_comb begin
    state_next = state;
    in_next    = samples_in_count;
    out_next   = samples_out_count;
    done_next  = 1'b0;
    cnt_start  = 1'b0;
    if (abort) begin
      state_next = MODE_IDLE;
      in_next    = CW'(0);
      out_next   = CW'(0);
    end else begin
      case (state)
        MODE_IDLE: begin
          if (start) state_next = MODE_LOAD;
          else       state_next = MODE_IDLE;
        end
        MODE_LOAD: begin
          if (sample_valid) begin
            if (samples_in_count == CW'(N - 1)) begin
              state_next = MODE_COMPUTE;
              in_next    = CW'(0);
              cnt_start  = 1'b1;
            end else begin
              in_next = samples_in_count + CW'(1);
            end
          end else begin
            in_next = samples_in_count;
          end
        end
        MODE_COMPUTE: begin
          if (compute_done) state_next = MODE_UNLOAD;
          else              state_next = MODE_COMPUTE;
        end
        MODE_UNLOAD: begin
          if (out_ready) begin
            if (samples_out_count == CW'(N - 1)) begin
              state_next = MODE_IDLE;
              out_next   = CW'(0);
              done_next  = 1'b1;
            end else begin
              out_next = samples_out_count + CW'(1);
            end
          end else begin
            out_next = samples_out_count;
          end
        end
        default: begin
          state_next = MODE_IDLE;
        end
      endcase
    end
  end

  // State, sample counters and done pulse; reset is synchronous active-low.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state             <= MODE_IDLE;
      samples_in_count  <= CW'(0);
      samples_out_count <= CW'(0);
      done              <= 1'b0;
    end else begin
      state             <= state_next;
      samples_in_count  <= in_next;
      samples_out_count <= out_next;
      done              <= done_next;
    end
  end

endmodule
